// File: rtl/pingpong_frame_reader_if.sv
// pingpong_frame_reader_if: buffer read port and downstream stream handshake bundle
interface pingpong_frame_reader_if #(
  parameter int WIDTH = 36
);
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;
  modport master (
    input  rd_data, rd_valid, m_ready,
    output rd_ready, m_data, m_valid, m_last
  );
  modport slave (
    output rd_data, rd_valid, m_ready,
    input  rd_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/pingpong_frame_reader.sv
// pingpong_frame_reader: drains one ping-pong frame per swap pulse into a registered stream with peak/overrun tracking
module pingpong_frame_reader #(
  parameter int WIDTH     = 36,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     frame_ready_i,
  pingpong_frame_reader_if.master  bus,
  output logic [WIDTH-1:0]         peak_o,
  output logic                     peak_valid_o,
  output logic                     overrun_o,
  output logic [15:0]              frame_count_o,
  output logic                     busy_o
);
  typedef enum logic [1:0] {
    DRAIN = 2'd0,
    FLUSH = 2'd1,
    IDLE  = 2'd3
  } state_t;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]     run_peak;
  logic                 rd_xfer;
  logic                 m_xfer;
  logic                 last_acc;
  logic                 restart;
  logic [WIDTH-1:0]     abs_x;
  logic [WIDTH-1:0]     peak_max;
  // read handshake, transfer qualifiers and magnitude of the incoming sample
  always_comb begin
    bus.rd_ready = state == DRAIN && (!bus.m_valid || bus.m_ready);
    busy_o       = state != IDLE;
    rd_xfer      = bus.rd_valid && bus.rd_ready;
    m_xfer       = bus.m_valid && bus.m_ready;
    last_acc     = rd_xfer && cnt == CNT_WIDTH'(DEPTH - 1);
    restart      = frame_ready_i && state != IDLE;
    abs_x        = bus.rd_data[WIDTH-1] ? -bus.rd_data : bus.rd_data;
    peak_max     = abs_x > run_peak ? abs_x : run_peak;
  end
  // frame FSM, output register and per-frame statistics
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= IDLE;
      cnt           <= '0;
      run_peak      <= '0;
      bus.m_data    <= '0;
      bus.m_valid   <= 1'b0;
      bus.m_last    <= 1'b0;
      peak_o        <= '0;
      peak_valid_o  <= 1'b0;
      overrun_o     <= 1'b0;
      frame_count_o <= '0;
    end else begin
      state        <= frame_ready_i ? DRAIN :
                      state == DRAIN ? (last_acc ? FLUSH : DRAIN) :
                      state == FLUSH && bus.m_valid && !m_xfer ? FLUSH : IDLE;
      if (rd_xfer) bus.m_data <= bus.rd_data;
      bus.m_valid  <= rd_xfer || (bus.m_valid && !bus.m_ready);
      bus.m_last   <= rd_xfer ? last_acc : bus.m_last && !bus.m_ready && !restart;
      cnt          <= restart || last_acc ? '0 : rd_xfer ? cnt + 1'b1 : cnt;
      run_peak     <= restart || last_acc ? '0 : rd_xfer ? peak_max : run_peak;
      peak_valid_o <= last_acc;
      overrun_o    <= restart;
      if (last_acc) begin
        peak_o        <= peak_max;
        frame_count_o <= frame_count_o + 16'd1;
      end
    end
  end
endmodule
